// File: rtl/vga_pkg.sv
// Shared VGA frame-buffer definitions: default resolution, pixel type and
// the write-scheduler state encoding.
package vga_pkg;

    localparam int H_RES_DEFAULT = 640;
    localparam int V_RES_DEFAULT = 480;
    localparam int FB_PIXELS     = H_RES_DEFAULT * V_RES_DEFAULT;
    localparam int PIXEL_W       = 24;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        CLEAR = 2'd2
    } state_t;

endpackage

// File: rtl/vmem_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, and on contention
// the port that did not win last time is picked.
module vmem_rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        unique case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/vmem_wr_arb.sv
// Video-memory write scheduler: round-robin between CPU and console ports plus
// a full-frame clear engine. Define VMEM_CLR_VSYNC_GATE_EN to hold a clear until vsync falls.
module vmem_wr_arb
    import vga_pkg::*;
#(
    parameter int H_RES = H_RES_DEFAULT,
    parameter int V_RES = V_RES_DEFAULT,
    parameter int AW    = 19,
    parameter int DW    = PIXEL_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vsync,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    input  logic          clr_start,
    input  logic [DW-1:0] clr_color,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic [7:0]    drop_cnt
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(H_RES * V_RES - 1);

    state_t        state_q, state_d;
    logic          last_grant_q;
    logic [1:0]    grant;
    logic          idle;
    logic          accept;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic [AW-1:0] clr_cnt_q;
    logic [DW-1:0] clr_color_q;
    logic          wr_en_q;
    logic [AW-1:0] wr_addr_q;
    logic [DW-1:0] wr_data_q;
    logic          clr_done_q;
    logic [7:0]    drop_cnt_q;
    logic          vsync_fall;

    vmem_rr_arb2 u_arb (
        .valid_i      ({req1_valid, req0_valid}),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

`ifdef VMEM_CLR_VSYNC_GATE_EN
    logic vsync_q;

    always_ff @(posedge clk) begin
        if (!rst) vsync_q <= 1'b1;
        else      vsync_q <= vsync;
    end

    assign vsync_fall = vsync_q & ~vsync;
`else
    logic unused_vsync;

    assign unused_vsync = vsync;
    assign vsync_fall   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (clr_start) begin
`ifdef VMEM_CLR_VSYNC_GATE_EN
                    state_d = ARM;
`else
                    state_d = CLEAR;
`endif
                end
            end
            ARM: begin
                if (vsync_fall) state_d = CLEAR;
            end
            CLEAR: begin
                if (clr_cnt_q == LAST_ADDR) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Requests are only served in IDLE; ARM and CLEAR own the write port.
    always_comb begin
        idle       = (state_q == IDLE);
        req0_ready = idle & grant[0];
        req1_ready = idle & grant[1];
        clr_busy   = ~idle;
        accept     = req0_ready | req1_ready;
        sel_addr   = grant[1] ? req1_addr : req0_addr;
        sel_data   = grant[1] ? req1_data : req0_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant_q <= 1'b1;
            clr_cnt_q    <= '0;
            clr_color_q  <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            clr_done_q   <= 1'b0;
            drop_cnt_q   <= 8'd0;
        end else begin
            wr_en_q    <= 1'b0;
            clr_done_q <= 1'b0;
            if (state_q == CLEAR) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= clr_cnt_q;
                wr_data_q <= clr_color_q;
                clr_cnt_q <= clr_cnt_q + AW'(1);
                if (clr_cnt_q == LAST_ADDR) clr_done_q <= 1'b1;
            end else if (accept) begin
                last_grant_q <= grant[1];
                // Off-screen writes are swallowed so the requester never stalls.
                if (sel_addr > LAST_ADDR) begin
                    if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
                end else begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= sel_addr;
                    wr_data_q <= sel_data;
                end
            end
            if (idle && clr_start) begin
                clr_color_q <= clr_color;
                clr_cnt_q   <= '0;
            end
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign clr_done = clr_done_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_vmem_wr_arb.sv
// Directed bench for vmem_wr_arb on a 16x8 frame so a full clear stays short.
// Also exercises the vsync-gated clear when VMEM_CLR_VSYNC_GATE_EN is defined.
module tb_vmem_wr_arb;

    localparam int H = 16;
    localparam int V = 8;
    localparam int AWT = 8;
    localparam int DWT = 24;
    localparam int PIX = H * V;

    logic clk = 1'b0;
    logic rst, vsync;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic [AWT-1:0] req0_addr, req1_addr, wr_addr;
    logic [DWT-1:0] req0_data, req1_data, wr_data, clr_color;
    logic clr_start, clr_busy, clr_done, wr_en;
    logic [7:0] drop_cnt;

    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        logic           rstN;
        logic           v0;
        logic [AWT-1:0] a0;
        logic [DWT-1:0] d0;
        logic           v1;
        logic [AWT-1:0] a1;
        logic [DWT-1:0] d1;
        logic           expR0;
        logic           expR1;
        logic           expEn;
        logic [AWT-1:0] expAddr;
        logic [DWT-1:0] expData;
        logic [7:0]     expDrop;
    } vec_t;

    vec_t vecs[12];

    vmem_wr_arb #(.H_RES(H), .V_RES(V), .AW(AWT), .DW(DWT)) dut (
        .clk        (clk),
        .rst        (rst),
        .vsync      (vsync),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .clr_start  (clr_start),
        .clr_color  (clr_color),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst        = v.rstN;
        req0_valid = v.v0;
        req0_addr  = v.a0;
        req0_data  = v.d0;
        req1_valid = v.v1;
        req1_addr  = v.a1;
        req1_data  = v.d1;
    endtask

    task automatic checkWrite(input string name, input logic en, input logic [AWT-1:0] addr, input logic [DWT-1:0] data);
        checkOutput({name, ".wr_en"}, 32'(wr_en), 32'(en));
        checkOutput({name, ".wr_addr"}, 32'(wr_addr), 32'(addr));
        checkOutput({name, ".wr_data"}, 32'(wr_data), 32'(data));
    endtask

    task automatic checkReadies(input string name, input logic r0, input logic r1);
        checkOutput({name, ".req0_ready"}, 32'(req0_ready), 32'(r0));
        checkOutput({name, ".req1_ready"}, 32'(req1_ready), 32'(r1));
    endtask

    initial begin
        logic found;

        rst = 1'b0; vsync = 1'b1;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        clr_start = 1'b0; clr_color = '0;

        vecs[0]  = '{1'b0, 1'b1, 8'd5,   24'hFF0000, 1'b0, 8'd0,   24'h000000, 1'b1, 1'b0, 1'b0, 8'd0,   24'h000000, 8'd0};
        vecs[1]  = '{1'b1, 1'b1, 8'd5,   24'hFF0000, 1'b0, 8'd0,   24'h000000, 1'b1, 1'b0, 1'b1, 8'd5,   24'hFF0000, 8'd0};
        vecs[2]  = '{1'b1, 1'b1, 8'd10,  24'h111111, 1'b1, 8'd20,  24'h222222, 1'b0, 1'b1, 1'b1, 8'd20,  24'h222222, 8'd0};
        vecs[3]  = '{1'b1, 1'b1, 8'd10,  24'h111111, 1'b1, 8'd21,  24'h222223, 1'b1, 1'b0, 1'b1, 8'd10,  24'h111111, 8'd0};
        vecs[4]  = '{1'b1, 1'b1, 8'd11,  24'h111112, 1'b1, 8'd21,  24'h222223, 1'b0, 1'b1, 1'b1, 8'd21,  24'h222223, 8'd0};
        vecs[5]  = '{1'b1, 1'b1, 8'd11,  24'h111112, 1'b1, 8'd22,  24'h222224, 1'b1, 1'b0, 1'b1, 8'd11,  24'h111112, 8'd0};
        vecs[6]  = '{1'b1, 1'b0, 8'd0,   24'h000000, 1'b1, 8'd128, 24'hABCDEF, 1'b0, 1'b1, 1'b0, 8'd11,  24'h111112, 8'd1};
        vecs[7]  = '{1'b1, 1'b0, 8'd0,   24'h000000, 1'b1, 8'd255, 24'h000000, 1'b0, 1'b1, 1'b0, 8'd11,  24'h111112, 8'd2};
        vecs[8]  = '{1'b1, 1'b1, 8'd127, 24'h00FF00, 1'b0, 8'd0,   24'h000000, 1'b1, 1'b0, 1'b1, 8'd127, 24'h00FF00, 8'd2};
        vecs[9]  = '{1'b1, 1'b0, 8'd0,   24'h000000, 1'b1, 8'd0,   24'h123456, 1'b0, 1'b1, 1'b1, 8'd0,   24'h123456, 8'd2};
        vecs[10] = '{1'b1, 1'b0, 8'd0,   24'h000000, 1'b0, 8'd0,   24'h000000, 1'b0, 1'b0, 1'b0, 8'd0,   24'h123456, 8'd2};
        vecs[11] = '{1'b1, 1'b1, 8'd1,   24'h000001, 1'b1, 8'd2,   24'h000002, 1'b1, 1'b0, 1'b1, 8'd1,   24'h000001, 8'd2};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkWrite("reset", 1'b0, 8'd0, 24'd0);
        checkOutput("reset.clr_busy", 32'(clr_busy), 32'd0);
        checkOutput("reset.clr_done", 32'(clr_done), 32'd0);
        checkOutput("reset.drop_cnt", 32'(drop_cnt), 32'd0);

        // Single-cycle vectors: readies mid-cycle, registered outputs after the edge
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkReadies($sformatf("vec%0d", i), vecs[i].expR0, vecs[i].expR1);
            @(posedge clk);
            #1;
            checkWrite($sformatf("vec%0d", i), vecs[i].expEn, vecs[i].expAddr, vecs[i].expData);
            checkOutput($sformatf("vec%0d.drop_cnt", i), 32'(drop_cnt), 32'(vecs[i].expDrop));
            checkOutput($sformatf("vec%0d.clr_busy", i), 32'(clr_busy), 32'd0);
        end

        // Drop counter saturation
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_addr = 8'd200; req1_data = 24'h0F0F0F;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (i == 99) checkOutput("drop.mid", 32'(drop_cnt), 32'd102);
        end
        checkOutput("drop.sat", 32'(drop_cnt), 32'd255);
        checkOutput("drop.wr_en", 32'(wr_en), 32'd0);
        checkOutput("drop.ready1", 32'(req1_ready), 32'd1);

        // Clear with a same-cycle request that must land first
        @(negedge clk);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 8'd3; req0_data = 24'hAAAAAA;
        clr_start = 1'b1; clr_color = 24'h0000FF;
        #1;
        checkOutput("clr.startReady0", 32'(req0_ready), 32'd1);
        @(posedge clk);
        #1;
        checkWrite("clr.preWrite", 1'b1, 8'd3, 24'hAAAAAA);
        checkOutput("clr.busyStart", 32'(clr_busy), 32'd1);
        @(negedge clk);
        clr_start = 1'b0;
        req0_addr = 8'd7; req0_data = 24'h070707;
        req1_valid = 1'b1; req1_addr = 8'd9; req1_data = 24'h090909;
        #1;
        checkReadies("clr.blocked", 1'b0, 1'b0);
`ifdef VMEM_CLR_VSYNC_GATE_EN
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checkOutput("arm.wr_en", 32'(wr_en), 32'd0);
            checkOutput("arm.busy", 32'(clr_busy), 32'd1);
            @(negedge clk);
            #1;
            checkReadies("arm", 1'b0, 1'b0);
        end
        vsync = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("arm.fallEdgeNoWrite", 32'(wr_en), 32'd0);
        checkOutput("arm.fallEdgeBusy", 32'(clr_busy), 32'd1);
`endif
        for (int k = 0; k < PIX; k++) begin
            @(posedge clk);
            #1;
            checkWrite($sformatf("clr%0d", k), 1'b1, AWT'(k), 24'h0000FF);
            checkOutput($sformatf("clr%0d.done", k), 32'(clr_done), 32'(k == PIX - 1));
            checkOutput($sformatf("clr%0d.busy", k), 32'(clr_busy), 32'(k != PIX - 1));
            @(negedge clk);
            if (k == 10) begin
                clr_start = 1'b1; clr_color = 24'hFF00FF;
            end else begin
                clr_start = 1'b0;
            end
            #1;
            if (k == PIX - 1) checkReadies("clr.after", 1'b0, 1'b1);
            else if (k % 16 == 0) checkReadies($sformatf("clr%0d", k), 1'b0, 1'b0);
        end
        @(posedge clk);
        #1;
        checkWrite("clr.post1", 1'b1, 8'd9, 24'h090909);
        checkOutput("clr.post1.done", 32'(clr_done), 32'd0);
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        checkOutput("clr.post2.ready0", 32'(req0_ready), 32'd1);
        @(posedge clk);
        #1;
        checkWrite("clr.post2", 1'b1, 8'd7, 24'h070707);
        @(negedge clk);
        req0_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("clr.quiet", 32'(wr_en), 32'd0);

        // Reset in the middle of a clear
        @(negedge clk);
        vsync = 1'b1;
        clr_start = 1'b1; clr_color = 24'h00AA00;
        @(negedge clk);
        clr_start = 1'b0;
        @(negedge clk);
        vsync = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(posedge clk);
            #1;
            if (wr_en && wr_addr == 8'd50) found = 1'b1;
        end
        checkOutput("rstClr.reach50", 32'(found), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b1; req0_addr = 8'd42; req0_data = 24'h654321;
        req1_valid = 1'b1; req1_addr = 8'd43; req1_data = 24'h000111;
        @(posedge clk);
        #1;
        checkWrite("rstClr", 1'b0, 8'd0, 24'd0);
        checkOutput("rstClr.busy", 32'(clr_busy), 32'd0);
        checkOutput("rstClr.done", 32'(clr_done), 32'd0);
        checkOutput("rstClr.drop", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkReadies("rstClr.first", 1'b1, 1'b0);
        @(posedge clk);
        #1;
        checkWrite("rstClr.req0", 1'b1, 8'd42, 24'h654321);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        checkReadies("rstClr.second", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        checkWrite("rstClr.req1", 1'b1, 8'd43, 24'h000111);
        @(negedge clk);
        req1_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rstClr.noClear", 32'(wr_en), 32'd0);
        checkOutput("rstClr.idleBusy", 32'(clr_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/vmem_wr_arb.md
Name: vmem_wr_arb

Overview:
- Write-side scheduler for the video memory that feeds the VGA scan-out path.
- Shares the single vmem write port between two requesters, port 0 (CPU MMIO) and port 1 (console/DMA engine), using round-robin arbitration.
- Contains a clear engine that sweeps the whole frame buffer with one colour.
- The vmem read side (h_addr/v_addr to vga_data) is untouched; this block drives only the write port.

Parameters:
- H_RES, 640, active pixels per line.
- V_RES, 480, active lines per frame.
- AW, 19, flat pixel-address width; must satisfy 2^AW >= H_RES*V_RES.
- DW, 24, pixel width, RGB888.

Ports:
- clk  in  1  system clock, same clock as the VGA controller.
- rst  in  1  synchronous, active-low reset.
- vsync  in  1  VGA vsync, active-low, same clock domain.
- req0_valid  in  1  port 0 write request.
- req0_ready  out  1  port 0 accepted this cycle.
- req0_addr  in  AW  port 0 flat pixel index (v*H_RES+h).
- req0_data  in  DW  port 0 pixel.
- req1_valid, req1_ready, req1_addr, req1_data: same as port 0, for port 1.
- clr_start  in  1  single-cycle pulse that starts a clear.
- clr_color  in  DW  clear colour, sampled with clr_start.
- clr_busy  out  1  high while the clear runs.
- clr_done  out  1  one-cycle pulse after the last clear write.
- wr_en  out  1  vmem write strobe.
- wr_addr  out  AW  vmem write address.
- wr_data  out  DW  vmem write data.
- drop_cnt  out  8  saturating count of out-of-range accepted writes.

Behaviour:
- Reset (rst=0 at a clk edge) forces the following values:
  - state=IDLE.
  - wr_en=0, wr_addr=0, wr_data=0.
  - clr_busy=0, clr_done=0, drop_cnt=0.
  - last_grant=1, so port 0 wins first.
  - Any clear in progress is aborted immediately; no further writes are issued.
- Handshake: a transfer occurs when valid & ready. Ready is combinational from state, the valids and last_grant. valid must hold until accepted.
- Arbitration applies in IDLE only:
  - Only one port valid: that port is granted.
  - Both valid: the port not equal to last_grant is granted.
  - last_grant updates on every grant.
  - At most one ready is high per cycle.
- Write latency is 1 cycle. A transfer accepted at edge N appears on wr_en/wr_addr/wr_data during cycle N+1. Outputs are registered.
- Out-of-range address (addr >= H_RES*V_RES):
  - The request is still accepted (ready=1).
  - wr_en stays 0 for that slot.
  - drop_cnt increments and saturates at 255.
- States are IDLE, ARM and CLEAR:
  - IDLE with clr_start=1: latch clr_color, then go to ARM (with the feature enabled) or CLEAR (without it).
  - A request accepted in the same cycle as clr_start is still written. It lands before the clear pixels.
  - CLEAR: clr_busy=1 and both readies are 0.
  - CLEAR issues one write per cycle, addresses 0 to H_RES*V_RES-1 ascending, data = latched colour.
  - On the cycle the last address is issued, return to IDLE; clr_done pulses in that same cycle.
  - clr_start while clr_busy=1 is ignored, and the colour is not re-latched.
  - The first write after CLEAR uses normal arbitration. last_grant is unchanged by the clear.
- No write is ever issued to an address >= H_RES*V_RES.

Optional Feature:
- Macro: VMEM_CLR_VSYNC_GATE_EN.
- Defined:
  - clr_start moves to ARM. clr_busy=1 and readies=0 while in ARM.
  - ARM waits for the falling edge of vsync (registered previous vsync=1, current=0).
  - CLEAR starts on the next cycle after that edge, so the sweep begins inside vertical blanking.
- Undefined: ARM does not exist; clr_start goes directly to CLEAR.
- Port list is identical in both builds.

Decomposition:
- Shared package vga_pkg holds:
  - H_RES/V_RES defaults, FB_PIXELS = H_RES*V_RES.
  - the pixel typedef (DW-bit RGB).
  - the state enum {IDLE, ARM, CLEAR}.
- One natural sub-module: vmem_rr_arb2, a 2-way round-robin grant (valids, last_grant in; grant one-hot out).
- The FSM, clear counter and output registers stay in the top block.

Test Plan:
- Reset, then req0_valid=1 with addr=5, data=0xFF0000 → req0_ready=1 in the same cycle; next cycle wr_en=1, wr_addr=5, wr_data=0xFF0000.
- Both ports valid for 4 cycles → grants go 0,1,0,1; never both readies high; wr_addr sequence matches.
- req1 with addr=307200 → accepted, wr_en=0, drop_cnt=1. Repeat 300 times → drop_cnt stays at 255.
- clr_start with clr_color=0x0000FF (gate undefined) → clr_busy for 307200 cycles; wr_addr runs 0..307199, each with data 0x0000FF; clr_done pulses on the cycle of write 307199; readies are 0 throughout.
- rst=0 at clear address 1000 → next cycle wr_en=0 and clr_busy=0. After reset release, req0 works with 1-cycle latency.
- With VMEM_CLR_VSYNC_GATE_EN: clr_start while vsync=1 → no writes until vsync falls; the first wr_addr=0 appears 2 cycles after the falling edge is sampled.
